mem_port_arbiter: RTL

- Sequences the single shared instruction/data memory port of the pipelined RISC-V core.
- Arbitrates between two requesters: the IF stage (fetch) and the MEM stage (load/store, driven by the decoder's memread/memwrite/memsizesel).
- Grants one transaction at a time and returns read data with a one-cycle ready pulse; the hazard logic uses ready to release stalls.
- Contains the FSM, an anti-starvation counter and a no-ack watchdog.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_watchdog.sv | 30 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// State codes, memory access size codes (decoder memsizesel), and small helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  localparam logic [1:0] SIZE_W = 2'b00;
  localparam logic [1:0] SIZE_B = 2'b01;
  localparam logic [1:0] SIZE_H = 2'b10;

  localparam int STARVE_W = 4;

  // The unused code 11 is issued to memory as a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    case (sz)
      SIZE_B:  return SIZE_B;
      SIZE_H:  return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] lim);
    return (v >= lim) ? lim : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// No-ack watchdog: loaded while the arbiter idles, counts during a transaction,
// and flags expiry so the transaction completes in cycle TIMEOUT after the grant.
module mem_port_arbiter_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] r_cnt;

  // The grant cycle itself counts as cycle 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
    end else if (i_count && !o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port sequencer: arbitrates fetch vs load/store,
// one transaction at a time, with anti-starvation for fetch and a no-ack watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_instr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

  arb_state_t          r_state;
  logic [STARVE_W-1:0] r_starve;
  logic                r_if_ready, r_d_ready, r_mem_req, r_mem_we, r_err;
  logic [31:0]         r_if_instr, r_d_rdata, r_mem_addr, r_mem_wdata;
  logic [1:0]          r_mem_size;

  logic w_dp, w_grant_d, w_expire, w_end, w_idle, w_busy;

  assign w_dp      = d_read | d_write;
  assign w_idle    = (r_state == ARB_IDLE);
  assign w_busy    = (r_state == ARB_BUSY_I) || (r_state == ARB_BUSY_D);
  assign w_grant_d = w_dp && !(if_req && (r_starve == SMAX));
  assign w_end     = mem_ack || w_expire;

  mem_port_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_idle),
    .i_count  (w_busy),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_starve    <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_err       <= 1'b0;
      r_if_instr  <= '0;
      r_d_rdata   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= SIZE_W;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d) begin
            r_state     <= ARB_BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_write;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_size  <= norm_size(d_size);
            if (if_req) r_starve <= sat_inc(r_starve, SMAX);
          end else if (if_req) begin
            r_state     <= ARB_BUSY_I;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_size  <= SIZE_W;
            r_starve    <= '0;
          end
        end
        ARB_BUSY_I: begin
          if (w_end) begin
            r_if_instr <= mem_ack ? mem_rdata : 32'h0;
            r_if_ready <= 1'b1;
            r_mem_req  <= 1'b0;
            r_err      <= r_err | ~mem_ack;
            r_state    <= ARB_DONE;
          end
        end
        ARB_BUSY_D: begin
          if (w_end) begin
            if (!r_mem_we) r_d_rdata <= mem_ack ? mem_rdata : 32'h0;
            r_d_ready <= 1'b1;
            r_mem_req <= 1'b0;
            r_err     <= r_err | ~mem_ack;
            r_state   <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          r_if_ready <= 1'b0;
          r_d_ready  <= 1'b0;
          r_state    <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign if_ready  = r_if_ready;
  assign if_instr  = r_if_instr;
  assign d_ready   = r_d_ready;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_size  = r_mem_size;
  assign err       = r_err;

endmodule
